game_state_controller: RTL and testbench

- Parametrised game-flow controller for the Frogger top level.
- Owns game state, lives, score and the post-hit freeze/respawn sequence.
- Takes debounced start/switch inputs and per-lane collision flags; drives game-active/freeze gating, life LEDs, score and level.
- Generalises the fixed 3-life IDLE/RUNNING flow to N lives and N lanes, adding hit-freeze, game-over hold, start re-arm and saturating score/level.

---
 rtl/game_state_controller_pkg.sv | 26 ++
 rtl/game_state_controller_if.sv | 36 +++
 rtl/game_state_controller_countdown_timer.sv | 27 ++
 rtl/game_state_controller.sv | 149 ++++++++++++++
 tb/tb_game_state_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/game_state_controller_pkg.sv
// Shared definitions for the Frogger game-flow controller: state encodings,
// default game tuning and small elaboration-time helpers.
package game_state_controller_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_HIT       = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_e;

  localparam int unsigned DEF_NUM_LIVES         = 3;
  localparam int unsigned DEF_NUM_LANES         = 4;
  localparam int unsigned DEF_SCORE_WIDTH       = 4;
  localparam int unsigned DEF_LEVEL_WIDTH       = 3;
  localparam int unsigned DEF_GOALS_PER_LEVEL   = 3;
  localparam int unsigned DEF_HIT_FREEZE_CYCLES = 12500000;  // 0.5 s at 25 MHz
  localparam int unsigned DEF_GAME_OVER_CYCLES  = 50000000;  // 2 s at 25 MHz

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Controller-facing bundle: player/collision inputs and game status outputs.
// master = the controller itself, slave = the surrounding top level.
interface game_state_controller_if
  import game_state_controller_pkg::*;
#(
  parameter int unsigned NUM_LIVES   = DEF_NUM_LIVES,
  parameter int unsigned NUM_LANES   = DEF_NUM_LANES,
  parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int unsigned LEVEL_WIDTH = DEF_LEVEL_WIDTH
) ();

  logic                   i_Start;
  logic [NUM_LANES-1:0]   i_Collision;
  logic                   i_Goal_Reached;
  logic [STATE_W-1:0]     o_State;
  logic                   o_Game_Active;
  logic                   o_Freeze;
  logic [NUM_LIVES-1:0]   o_Lives;
  logic [SCORE_WIDTH-1:0] o_Score;
  logic [LEVEL_WIDTH-1:0] o_Level;
  logic                   o_Respawn;
  logic                   o_Game_Over;

  modport master (
    input  i_Start, i_Collision, i_Goal_Reached,
    output o_State, o_Game_Active, o_Freeze, o_Lives, o_Score, o_Level,
           o_Respawn, o_Game_Over
  );

  modport slave (
    output i_Start, i_Collision, i_Goal_Reached,
    input  o_State, o_Game_Active, o_Freeze, o_Lives, o_Score, o_Level,
           o_Respawn, o_Game_Over
  );

endinterface

// File: rtl/game_state_controller_countdown_timer.sv
// Loadable down-counter shared by the hit-freeze and game-over holds.
// o_Done is decoded from the count register and is high while the count is zero.
module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Value,
  output logic             o_Done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count_q <= '0;
    end else if (i_Load) begin
      count_q <= i_Value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign o_Done = (count_q == '0);

endmodule

// File: rtl/game_state_controller.sv
// Frogger game-flow controller: game state, lives, score/level and the
// post-hit freeze / respawn and game-over hold sequences.
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter int unsigned NUM_LIVES         = DEF_NUM_LIVES,
  parameter int unsigned NUM_LANES         = DEF_NUM_LANES,
  parameter int unsigned SCORE_WIDTH       = DEF_SCORE_WIDTH,
  parameter int unsigned GOALS_PER_LEVEL   = DEF_GOALS_PER_LEVEL,
  parameter int unsigned LEVEL_WIDTH       = DEF_LEVEL_WIDTH,
  parameter int unsigned HIT_FREEZE_CYCLES = DEF_HIT_FREEZE_CYCLES,
  parameter int unsigned GAME_OVER_CYCLES  = DEF_GAME_OVER_CYCLES
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  game_state_controller_if.master  bus
);

  // A zero-length hold still needs one cycle in the hold state.
  localparam int unsigned HIT_EFF = max_u(HIT_FREEZE_CYCLES, 1);
  localparam int unsigned GO_EFF  = max_u(GAME_OVER_CYCLES, 1);
  localparam int unsigned TIMER_W = $clog2(max_u(HIT_EFF, GO_EFF) + 1);
  localparam int unsigned GOAL_W  = $clog2(GOALS_PER_LEVEL + 1);

  game_state_e            state_q, state_d;
  logic [NUM_LIVES-1:0]   lives_q, lives_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [GOAL_W-1:0]      goal_cnt_q, goal_cnt_d;
  logic                   respawn_q, respawn_d;
  logic                   game_over_q, game_over_d;
  logic                   armed_q, armed_d;
  logic                   coll_hist_q;
  logic [NUM_LANES-1:0]   coll_lanes;
  logic                   coll_any, coll_event;
  logic                   timer_load, timer_done;
  logic [TIMER_W-1:0]     timer_value;

  assign coll_lanes = bus.i_Collision;
  assign coll_any   = |coll_lanes;
  assign coll_event = coll_any & ~coll_hist_q;

  countdown_timer #(.WIDTH(TIMER_W)) u_timer (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Load  (timer_load),
    .i_Value (timer_value),
    .o_Done  (timer_done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= '1;
      score_q     <= '0;
      level_q     <= '0;
      goal_cnt_q  <= '0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      armed_q     <= 1'b0;
      coll_hist_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      level_q     <= level_d;
      goal_cnt_q  <= goal_cnt_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
      armed_q     <= armed_d;
      coll_hist_q <= coll_any;
    end
  end

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    level_d     = level_q;
    goal_cnt_d  = goal_cnt_q;
    respawn_d   = 1'b0;
    game_over_d = 1'b0;
    armed_d     = armed_q;
    timer_load  = 1'b0;
    timer_value = '0;

    case (state_q)
      ST_IDLE: begin
        // Start must be seen low in IDLE before it can launch a game.
        if (!bus.i_Start) armed_d = 1'b1;
        if (armed_q && bus.i_Start) begin
          lives_d    = '1;
          score_d    = '0;
          level_d    = '0;
          goal_cnt_d = '0;
          respawn_d  = 1'b1;
          state_d    = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (coll_event) begin
          timer_load = 1'b1;
          if (lives_q == NUM_LIVES'(1)) begin
            lives_d     = '0;
            game_over_d = 1'b1;
            timer_value = TIMER_W'(GO_EFF - 1);
            state_d     = ST_GAME_OVER;
          end else begin
            lives_d     = lives_q >> 1;
            timer_value = TIMER_W'(HIT_EFF - 1);
            state_d     = ST_HIT;
          end
        end else if (bus.i_Goal_Reached) begin
          respawn_d = 1'b1;
          if (score_q != '1) score_d = score_q + SCORE_WIDTH'(1);
          if (goal_cnt_q == GOAL_W'(GOALS_PER_LEVEL - 1)) begin
            goal_cnt_d = '0;
            if (level_q != '1) level_d = level_q + LEVEL_WIDTH'(1);
          end else begin
            goal_cnt_d = goal_cnt_q + GOAL_W'(1);
          end
        end
      end
      ST_HIT: begin
        if (timer_done) begin
          respawn_d = 1'b1;
          state_d   = ST_RUNNING;
        end
      end
      ST_GAME_OVER: begin
        if (timer_done) begin
          armed_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_State       = state_q;
  assign bus.o_Game_Active = (state_q == ST_RUNNING);
  assign bus.o_Freeze      = (state_q == ST_HIT) || (state_q == ST_GAME_OVER);
  assign bus.o_Lives       = lives_q;
  assign bus.o_Score       = score_q;
  assign bus.o_Level       = level_q;
  assign bus.o_Respawn     = respawn_q;
  assign bus.o_Game_Over   = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboarded bench for game_state_controller: directed game scenarios followed
// by random play, compared each cycle against a count-based game model.
module tb_game_state_controller;

  localparam int NL  = 3;
  localparam int NLN = 4;
  localparam int SW  = 4;
  localparam int LW  = 3;
  localparam int GPL = 3;
  localparam int HFC = 4;
  localparam int GOC = 20;
  localparam int SCORE_MAX = (1 << SW) - 1;
  localparam int LEVEL_MAX = (1 << LW) - 1;

  typedef struct {
    int state;
    int lives;
    int score;
    int level;
    int respawn;
    int game_over;
    int active;
    int freeze;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: lives as a count, goals as a running total since start.
  int m_phase, m_lives, m_goals, m_rem;
  bit m_prev, m_armed, m_resp, m_go;

  always #5 clk = ~clk;

  game_state_controller_if #(.NUM_LIVES(NL), .NUM_LANES(NLN),
                             .SCORE_WIDTH(SW), .LEVEL_WIDTH(LW)) gs ();

  game_state_controller #(
    .NUM_LIVES(NL), .NUM_LANES(NLN), .SCORE_WIDTH(SW), .GOALS_PER_LEVEL(GPL),
    .LEVEL_WIDTH(LW), .HIT_FREEZE_CYCLES(HFC), .GAME_OVER_CYCLES(GOC)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (gs.master)
  );

  task automatic model_step(input bit r, input bit s, input bit any, input bit g);
    bit ev;
    m_resp = 0;
    m_go   = 0;
    if (r) begin
      m_phase = 0; m_lives = NL; m_goals = 0; m_rem = 0; m_prev = 0; m_armed = 0;
      return;
    end
    ev     = any && !m_prev;
    m_prev = any;
    case (m_phase)
      0: begin
        if (s && m_armed) begin
          m_lives = NL; m_goals = 0; m_resp = 1; m_phase = 1;
        end
        if (!s) m_armed = 1;
      end
      1: begin
        if (ev) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_go = 1; m_rem = GOC; m_phase = 3;
          end else begin
            m_rem = (HFC < 1) ? 1 : HFC; m_phase = 2;
          end
        end else if (g) begin
          m_goals = m_goals + 1; m_resp = 1;
        end
      end
      2: begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_resp = 1; m_phase = 1; end
      end
      default: begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_armed = 0; m_phase = 0; end
      end
    endcase
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input bit r, input bit s, input logic [NLN-1:0] c, input bit g);
    exp_t e;
    @(negedge clk);
    rst               = r;
    gs.i_Start        = s;
    gs.i_Collision    = c;
    gs.i_Goal_Reached = g;
    model_step(r, s, c != '0, g);
    e.state     = m_phase;
    e.lives     = (1 << m_lives) - 1;
    e.score     = (m_goals > SCORE_MAX) ? SCORE_MAX : m_goals;
    e.level     = ((m_goals / GPL) > LEVEL_MAX) ? LEVEL_MAX : (m_goals / GPL);
    e.respawn   = int'(m_resp);
    e.game_over = int'(m_go);
    e.active    = (m_phase == 1) ? 1 : 0;
    e.freeze    = (m_phase >= 2) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv)
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, expv);
    else
      n_pass++;
  endtask

  // Monitor: every presented output cycle is popped and compared.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",     32'(gs.o_State),       32'(e.state));
      chk("lives",     32'(gs.o_Lives),       32'(e.lives));
      chk("score",     32'(gs.o_Score),       32'(e.score));
      chk("level",     32'(gs.o_Level),       32'(e.level));
      chk("respawn",   32'(gs.o_Respawn),     32'(e.respawn));
      chk("game_over", 32'(gs.o_Game_Over),   32'(e.game_over));
      chk("active",    32'(gs.o_Game_Active), 32'(e.active));
      chk("freeze",    32'(gs.o_Freeze),      32'(e.freeze));
    end
  end

  initial begin
    bit prev_goal;
    bit gl;
    logic [NLN-1:0] cv;
    rst = 1'b1;
    gs.i_Start = 1'b0;
    gs.i_Collision = '0;
    gs.i_Goal_Reached = 1'b0;

    repeat (3) cyc(1, 0, '0, 0);
    repeat (2) cyc(0, 0, '0, 0);
    cyc(0, 1, '0, 0);
    repeat (2) cyc(0, 0, '0, 0);

    repeat (10) begin cyc(0, 0, '0, 1); cyc(0, 0, '0, 0); end

    // Held collision counts once; goals inside the freeze are dropped.
    for (int i = 0; i < 10; i++) cyc(0, 0, 4'b0100, (i == 1 || i == 3));
    repeat (2) cyc(0, 0, '0, 0);

    repeat (7) begin cyc(0, 0, '0, 1); cyc(0, 0, '0, 0); end

    cyc(0, 0, 4'b0001, 1);
    repeat (8) cyc(0, 0, '0, 0);

    // Final life lost with start held: no restart until start is re-asserted.
    cyc(0, 1, 4'b1000, 0);
    repeat (GOC + 5) cyc(0, 1, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 1, '0, 0);
    repeat (2) cyc(0, 0, '0, 0);

    cyc(0, 0, 4'b0010, 0);
    repeat (2) cyc(0, 0, '0, 0);
    cyc(1, 0, '0, 0);
    repeat (3) cyc(0, 0, '0, 0);

    prev_goal = 0;
    for (int i = 0; i < 3000; i++) begin
      cv = ($urandom_range(0, 5) == 0) ? NLN'($urandom) : '0;
      gl = !prev_goal && ($urandom_range(0, 3) == 0);
      prev_goal = gl;
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 3), cv, gl);
    end
    cyc(0, 0, '0, 0);

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
